fitness_session_scheduler: RTL and testbench

//  Queues user workout requests (packed {weight,calories,met,gender} codes), drives the

---
 rtl/fitness_session_scheduler.sv | 209 ++++++++++++++++++++
 tb/tb_fitness_session_scheduler.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fitness_session_scheduler.sv
// Workout session scheduler: queues request codes, feeds the shared calculator, times sessions.
// Optional macro REST_GAP_EN inserts a REST_CYCLES idle gap after each completed session.
module fitness_session_scheduler #(
    parameter int CYCLES_PER_MIN = 6000,
    parameter int QUEUE_DEPTH    = 4,
    parameter int REST_CYCLES    = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [7:0]                     req_code,
    output logic [7:0]                     calc_code,
    input  logic [7:0]                     calc_minutes,
    input  logic                           pause,
    input  logic                           abort,
    output logic                           session_active,
    output logic [7:0]                     minutes_left,
    output logic                           session_done,
    output logic                           session_aborted,
    output logic [$clog2(QUEUE_DEPTH):0]   queue_count
);

    // state   | meaning
    // IDLE    | waiting for a queued request; pops head into calc_code
    // LOAD    | calculator settling on calc_code; result captured at end of cycle
    // RUN     | counting workout minutes
    // PAUSE   | session frozen while pause is high
    // REST    | post-session gap (REST_GAP_EN builds only)

    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = $clog2(CYCLES_PER_MIN);
    localparam int RW = (REST_CYCLES > 1) ? $clog2(REST_CYCLES) : 1;

    generate
        if (CYCLES_PER_MIN < 2 || QUEUE_DEPTH < 2 || REST_CYCLES < 1 ||
            (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0) begin : g_bad_param
            $error("fitness_session_scheduler: illegal parameter set");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3
`ifdef REST_GAP_EN
        ,S_REST = 3'd4
`endif
    } state_t;

    state_t          state, state_nxt;
    logic [7:0]      fifo_mem [QUEUE_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            push, pop, fifo_empty;
    logic [PW-1:0]   presc, presc_nxt;
    logic [7:0]      calc_code_nxt, minutes_nxt;
    logic            done_nxt, aborted_nxt;
    logic            finish, kill;
`ifdef REST_GAP_EN
    logic [RW-1:0]   rest_cnt, rest_nxt;
`endif

    assign fifo_empty     = (count == '0);
    assign req_ready      = (count != CW'(QUEUE_DEPTH));
    assign push           = req_valid && req_ready;
    assign queue_count    = count;
    assign session_active = (state == S_RUN) || (state == S_PAUSE);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= req_code;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            calc_code       <= '0;
            minutes_left    <= '0;
            presc           <= '0;
            session_done    <= 1'b0;
            session_aborted <= 1'b0;
        end else begin
            state           <= state_nxt;
            calc_code       <= calc_code_nxt;
            minutes_left    <= minutes_nxt;
            presc           <= presc_nxt;
            session_done    <= done_nxt;
            session_aborted <= aborted_nxt;
        end
    end

`ifdef REST_GAP_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rest_cnt <= '0;
        end else begin
            rest_cnt <= rest_nxt;
        end
    end
`endif

    always_comb begin
        state_nxt     = state;
        calc_code_nxt = calc_code;
        minutes_nxt   = minutes_left;
        presc_nxt     = presc;
        done_nxt      = 1'b0;
        aborted_nxt   = 1'b0;
        pop           = 1'b0;
        finish        = 1'b0;
        kill          = 1'b0;
`ifdef REST_GAP_EN
        rest_nxt      = rest_cnt;
`endif
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop           = 1'b1;
                    calc_code_nxt = fifo_mem[rd_ptr];
                    state_nxt     = S_LOAD;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    kill = 1'b1;
                end else begin
                    minutes_nxt = calc_minutes;
                    presc_nxt   = '0;
                    if (calc_minutes == 8'd0) begin
                        finish = 1'b1;
                    end else begin
                        state_nxt = S_RUN;
                    end
                end
            end
            // Releasing pause counts in the same cycle, so N paused cycles delay done by exactly N.
            S_RUN, S_PAUSE: begin
                if (abort) begin
                    kill = 1'b1;
                end else if (pause) begin
                    state_nxt = S_PAUSE;
                end else begin
                    state_nxt = S_RUN;
                    if (presc == PW'(CYCLES_PER_MIN - 1)) begin
                        presc_nxt = '0;
                        if (minutes_left != 8'd0) begin
                            minutes_nxt = minutes_left - 8'd1;
                        end
                        if (minutes_left <= 8'd1) begin
                            finish = 1'b1;
                        end
                    end else begin
                        presc_nxt = presc + PW'(1);
                    end
                end
            end
`ifdef REST_GAP_EN
            S_REST: begin
                if (rest_cnt == '0) begin
                    state_nxt = S_IDLE;
                end else begin
                    rest_nxt = rest_cnt - RW'(1);
                end
            end
`endif
            default: state_nxt = S_IDLE;
        endcase

        if (kill) begin
            aborted_nxt = 1'b1;
            minutes_nxt = 8'd0;
            presc_nxt   = '0;
            state_nxt   = S_IDLE;
        end else if (finish) begin
            done_nxt = 1'b1;
`ifdef REST_GAP_EN
            state_nxt = S_REST;
            rest_nxt  = RW'(REST_CYCLES - 1);
`else
            state_nxt = S_IDLE;
`endif
        end
    end

endmodule

// File: tb/tb_fitness_session_scheduler.sv
// Directed bench for fitness_session_scheduler with a table-driven calculator model.
module tb_fitness_session_scheduler;

`ifdef REST_GAP_EN
    localparam int REST_EXTRA = 8;
`else
    localparam int REST_EXTRA = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_code;
    logic [7:0] calc_code;
    logic [7:0] calc_minutes;
    logic       pause;
    logic       abort;
    logic       session_active;
    logic [7:0] minutes_left;
    logic       session_done;
    logic       session_aborted;
    logic [2:0] queue_count;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    fitness_session_scheduler #(
        .CYCLES_PER_MIN (4),
        .QUEUE_DEPTH    (4),
        .REST_CYCLES    (8)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_code        (req_code),
        .calc_code       (calc_code),
        .calc_minutes    (calc_minutes),
        .pause           (pause),
        .abort           (abort),
        .session_active  (session_active),
        .minutes_left    (minutes_left),
        .session_done    (session_done),
        .session_aborted (session_aborted),
        .queue_count     (queue_count)
    );

    function automatic logic [7:0] calc_fn(input logic [7:0] c);
        case (c)
            8'hA5:   return 8'd3;
            8'h11:   return 8'd1;
            8'h3C:   return 8'd2;
            8'h42:   return 8'd0;
            default: return 8'd50;
        endcase
    endfunction

    assign calc_minutes = calc_fn(calc_code);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] q_codes [5];

    initial begin
        q_codes[0] = 8'h11;
        q_codes[1] = 8'h3C;
        q_codes[2] = 8'h42;
        q_codes[3] = 8'h44;
        q_codes[4] = 8'h55;

        // reset with req_valid asserted
        rst_n = 1'b0; req_valid = 1'b1; req_code = 8'hFF; pause = 1'b0; abort = 1'b0;
        tick; tick;
        chk("rst_ready",   req_ready,       1);
        chk("rst_count",   queue_count,     0);
        chk("rst_active",  session_active,  0);
        chk("rst_minutes", minutes_left,    0);
        chk("rst_code",    calc_code,       0);
        chk("rst_done",    session_done,    0);
        chk("rst_aborted", session_aborted, 0);
        rst_n = 1'b1; req_valid = 1'b0;
        tick;
        chk("idle_count", queue_count, 0);

        // single session A5 -> 3 minutes
        req_valid = 1'b1; req_code = 8'hA5;
        tick;
        req_valid = 1'b0;
        chk("s_push_count", queue_count, 1);
        tick;
        chk("s_calc_code", calc_code, 8'hA5);
        chk("s_load_inactive", session_active, 0);
        chk("s_pop_count", queue_count, 0);
        tick;
        chk("s_minutes_load", minutes_left, 3);
        chk("s_active", session_active, 1);
        for (int i = 1; i <= 12; i++) begin
            tick;
            if (i == 3)  chk("s_min_before_dec", minutes_left, 3);
            if (i == 4)  chk("s_min_first_dec", minutes_left, 2);
            if (i == 8)  chk("s_min_second_dec", minutes_left, 1);
            if (i == 11) chk("s_done_early", session_done, 0);
            if (i == 12) begin
                chk("s_done", session_done, 1);
                chk("s_min_zero", minutes_left, 0);
                chk("s_inactive", session_active, 0);
            end
        end
        tick;
        chk("s_done_one_cycle", session_done, 0);
        repeat (REST_EXTRA) tick;

        // long session, paused, then fill queue
        req_valid = 1'b1; req_code = 8'h77;
        tick;
        req_valid = 1'b0;
        tick;
        tick;
        chk("f_minutes", minutes_left, 50);
        pause = 1'b1;
        tick;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req_code = q_codes[i];
            tick;
            if (i == 2) chk("f_ready_3", req_ready, 1);
            if (i == 3) begin
                chk("f_ready_full", req_ready, 0);
                chk("f_count_full", queue_count, 4);
            end
            if (i == 4) chk("f_count_5th", queue_count, 4);
        end
        req_valid = 1'b0;
        chk("f_paused_minutes", minutes_left, 50);
        chk("f_paused_active", session_active, 1);

        // abort while paused (abort beats pause)
        abort = 1'b1;
        tick;
        chk("a_pause_aborted", session_aborted, 1);
        chk("a_pause_done", session_done, 0);
        chk("a_pause_minutes", minutes_left, 0);
        chk("a_pause_inactive", session_active, 0);
        abort = 1'b0; pause = 1'b0;
        tick;
        chk("a_pulse_one_cycle", session_aborted, 0);
        chk("a_pop_code", calc_code, 8'h11);
        chk("a_pop_count", queue_count, 3);
        chk("a_ready_back", req_ready, 1);

        // abort on the terminal count of the last minute
        tick;
        chk("t_minutes", minutes_left, 1);
        repeat (3) tick;
        abort = 1'b1;
        tick;
        chk("t_aborted", session_aborted, 1);
        chk("t_no_done", session_done, 0);
        chk("t_minutes_zero", minutes_left, 0);
        abort = 1'b0;
        tick;
        chk("t_next_pop", calc_code, 8'h3C);
        chk("t_next_count", queue_count, 2);
        chk("t_done_quiet", session_done, 0);

        // pause 10 cycles mid-minute with 2 minutes left
        tick;
        chk("p_minutes", minutes_left, 2);
        tick; tick;
        pause = 1'b1;
        repeat (10) tick;
        chk("p_frozen_minutes", minutes_left, 2);
        chk("p_frozen_active", session_active, 1);
        chk("p_frozen_done", session_done, 0);
        pause = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick;
            if (i == 2) chk("p_first_dec", minutes_left, 1);
            if (i == 5) chk("p_done_early", session_done, 0);
            if (i == 6) chk("p_done", session_done, 1);
        end

        // zero-minute request, popped after optional rest gap
        repeat (REST_EXTRA) tick;
        chk("z_code_held", calc_code, 8'h3C);
        chk("z_count_held", queue_count, 2);
        tick;
        chk("z_pop_code", calc_code, 8'h42);
        chk("z_pop_count", queue_count, 1);
        tick;
        chk("z_done", session_done, 1);
        chk("z_inactive", session_active, 0);
        chk("z_minutes", minutes_left, 0);
        tick;
        chk("z_done_one_cycle", session_done, 0);
        chk("z_no_run", session_active, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
